// File: rtl/psx_poller.sv
// Host-side initiator for the PSX digital-pad serial link: sends the 5-byte poll
// command, captures the pad reply and reports buttons, pad ID and status.
module psx_poller #(
    parameter int CLK_DIV      = 4,
    parameter int SETUP_CYCLES = 8,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        valid,
    output logic [7:0]  id,
    output logic [15:0] pad_data,
    output logic        psx_clk,
    output logic        cmd,
    output logic        att,
    input  logic        data,
    input  logic        ack
);

    // state   | meaning
    // IDLE    | lines released, waiting for start (busy still high in the done cycle)
    // SETUP   | att low, delay before the first psx_clk fall
    // BIT_LO  | psx_clk low, cmd bit driven, data sampled on last cycle
    // BIT_HI  | psx_clk high
    // ACK_LO  | waiting for the pad to pull ack low
    // ACK_HI  | waiting for ack to return high
    // RELEASE | att/psx_clk/cmd high for one half-period, then done
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_BIT_LO  = 3'd2;
    localparam logic [2:0] S_BIT_HI  = 3'd3;
    localparam logic [2:0] S_ACK_LO  = 3'd4;
    localparam logic [2:0] S_ACK_HI  = 3'd5;
    localparam logic [2:0] S_RELEASE = 3'd6;

    localparam int CNT_MAX = (CLK_DIV > SETUP_CYCLES) ? CLK_DIV : SETUP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int TMO_W   = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DIV_LOAD   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD   = TMO_W'(ACK_TIMEOUT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       byte_idx;
    logic [7:0]       shift_reg;
    logic [7:0]       rx_byte [5];

    logic data_s1, data_s;
    logic ack_s1, ack_s;

    function automatic logic cmd_bit(input logic [2:0] byte_i, input logic [2:0] bit_i);
        logic [7:0] b;
        case (byte_i)
            3'd0:    b = 8'h01;
            3'd1:    b = 8'h42;
            default: b = 8'h00;
        endcase
        return b[bit_i];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_s1 <= 1'b1;
            data_s  <= 1'b1;
            ack_s1  <= 1'b1;
            ack_s   <= 1'b1;
        end else begin
            data_s1 <= data;
            data_s  <= data_s1;
            ack_s1  <= ack;
            ack_s   <= ack_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            tmo_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
            shift_reg   <= '0;
            for (int i = 0; i < 5; i++) rx_byte[i] <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            valid       <= 1'b0;
            id          <= 8'h00;
            pad_data    <= 16'hFFFF;
            psx_clk     <= 1'b1;
            cmd         <= 1'b1;
            att         <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy is only still high here during the done cycle; a start then is dropped
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        state       <= S_SETUP;
                        busy        <= 1'b1;
                        att         <= 1'b0;
                        timeout_err <= 1'b0;
                        valid       <= 1'b0;
                        cnt         <= SETUP_LOAD;
                        bit_idx     <= '0;
                        byte_idx    <= '0;
                    end
                end

                S_SETUP: begin
                    if (cnt == '0) begin
                        state   <= S_BIT_LO;
                        psx_clk <= 1'b0;
                        cmd     <= cmd_bit(3'd0, 3'd0);
                        cnt     <= DIV_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_BIT_LO: begin
                    if (cnt == '0) begin
                        shift_reg <= {data_s, shift_reg[7:1]};
                        state     <= S_BIT_HI;
                        psx_clk   <= 1'b1;
                        cnt       <= DIV_LOAD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_BIT_HI: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else if (bit_idx != 3'd7) begin
                        bit_idx <= bit_idx + 3'd1;
                        state   <= S_BIT_LO;
                        psx_clk <= 1'b0;
                        cmd     <= cmd_bit(byte_idx, bit_idx + 3'd1);
                        cnt     <= DIV_LOAD;
                    end else begin
                        rx_byte[byte_idx] <= shift_reg;
                        bit_idx           <= '0;
                        if (byte_idx == 3'd4) begin
                            state   <= S_RELEASE;
                            att     <= 1'b1;
                            psx_clk <= 1'b1;
                            cmd     <= 1'b1;
                            cnt     <= DIV_LOAD;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= S_ACK_LO;
                            tmo_cnt  <= TMO_LOAD;
                        end
                    end
                end

                // one timeout budget covers the whole ack pulse, low and high phases
                S_ACK_LO, S_ACK_HI: begin
                    if (state == S_ACK_LO && !ack_s) begin
                        state <= S_ACK_HI;
                    end else if (state == S_ACK_HI && ack_s) begin
                        state   <= S_BIT_LO;
                        psx_clk <= 1'b0;
                        cmd     <= cmd_bit(byte_idx, 3'd0);
                        cnt     <= DIV_LOAD;
                    end else if (tmo_cnt == '0) begin
                        timeout_err <= 1'b1;
                        state       <= S_RELEASE;
                        att         <= 1'b1;
                        psx_clk     <= 1'b1;
                        cmd         <= 1'b1;
                        cnt         <= DIV_LOAD;
                    end else begin
                        tmo_cnt <= tmo_cnt - TMO_W'(1);
                    end
                end

                S_RELEASE: begin
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                        if (!timeout_err) begin
                            id <= rx_byte[1];
                            if (rx_byte[2] == 8'h5A) begin
                                valid    <= 1'b1;
                                pad_data <= {rx_byte[4], rx_byte[3]};
                            end
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_psx_poller.sv
// Bench for psx_poller: two instances (CLK_DIV 4 and 3), each talking to a
// behavioural pad model that replies per a table and acks a fixed delay after each byte.
`timescale 1ns/1ps
module tb_psx_poller;

    localparam int SETUP = 8;
    localparam int TMO   = 64;
    localparam int DIV0  = 4;
    localparam int DIV1  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [1:0]  start_v = '0;
    logic [1:0]  busy_v, done_v, to_v, valid_v, psx_clk_v, cmd_v, att_v;
    logic [7:0]  id_v [2];
    logic [15:0] pd_v [2];

    logic [7:0] reply_cfg [2][5];
    logic [3:0] ack_mask [2];
    int         ack_k [2] = '{4, 20};

    for (genvar g = 0; g < 2; g++) begin : g_pad
        localparam int DIV = (g == 0) ? DIV0 : DIV1;
        logic data_p  = 1'b1;
        logic ack_p   = 1'b1;
        logic ack_low = 1'b0;
        logic prev_clk = 1'b1;
        logic prev_att = 1'b1;
        int   bitn = 0;
        int   bytn = 0;
        int   ack_wait = -1;
        int   falls = 0;
        logic [7:0] cmd_cap [5];

        psx_poller #(.CLK_DIV(DIV), .SETUP_CYCLES(SETUP), .ACK_TIMEOUT(TMO)) u_dut (
            .clk(clk),
            .rst(rst),
            .start(start_v[g]),
            .busy(busy_v[g]),
            .done(done_v[g]),
            .timeout_err(to_v[g]),
            .valid(valid_v[g]),
            .id(id_v[g]),
            .pad_data(pd_v[g]),
            .psx_clk(psx_clk_v[g]),
            .cmd(cmd_v[g]),
            .att(att_v[g]),
            .data(data_p),
            .ack(ack_p)
        );

        // Pad: drives reply bit on psx_clk fall, latches cmd on rise, acks
        // ack_k cycles after the last rise of bytes 0-3 when enabled by ack_mask.
        initial begin
            forever begin
                @(negedge clk);
                if (rst || att_v[g]) begin
                    ack_p    = 1'b1;
                    ack_low  = 1'b0;
                    ack_wait = -1;
                    bitn     = 0;
                    bytn     = 0;
                    data_p   = 1'b1;
                end else begin
                    if (prev_att) begin
                        falls = 0;
                        for (int i = 0; i < 5; i++) cmd_cap[i] = 8'h00;
                    end
                    if (ack_low) begin
                        ack_p   = 1'b1;
                        ack_low = 1'b0;
                    end
                    if (ack_wait > 0) begin
                        ack_wait = ack_wait - 1;
                        if (ack_wait == 0) begin
                            ack_p    = 1'b0;
                            ack_low  = 1'b1;
                            ack_wait = -1;
                        end
                    end
                    if (prev_clk && !psx_clk_v[g]) begin
                        falls = falls + 1;
                        if (bytn < 5) data_p = reply_cfg[g][bytn][bitn];
                    end
                    if (!prev_clk && psx_clk_v[g] && bytn < 5) begin
                        cmd_cap[bytn][bitn] = cmd_v[g];
                        if (bitn == 7) begin
                            if (bytn < 4 && ack_mask[g][bytn]) ack_wait = ack_k[g];
                            bitn = 0;
                            bytn = bytn + 1;
                        end else begin
                            bitn = bitn + 1;
                        end
                    end
                end
                prev_clk = psx_clk_v[g];
                prev_att = att_v[g];
            end
        end
    end

    typedef struct {
        logic [39:0] rep;       // {b4,b3,b2,b1,b0}
        logic [3:0]  mask;
        logic        exp_to;
        logic        exp_valid;
        logic [7:0]  exp_id;
        logic [15:0] exp_pd;
        int          exp_falls;
        int          exp_lat;
    } vec_t;

    logic [7:0] cmd_exp [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int falls_of(input int u);
        return (u == 0) ? g_pad[0].falls : g_pad[1].falls;
    endfunction

    function automatic logic [7:0] cmd_of(input int u, input int i);
        return (u == 0) ? g_pad[0].cmd_cap[i] : g_pad[1].cmd_cap[i];
    endfunction

    task automatic run_poll(input int u, output int lat);
        int t0;
        @(negedge clk);
        start_v[u] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[u] = 1'b0;
        lat = -1;
        for (int i = 0; i < 4000; i++) begin
            if (done_v[u]) begin
                lat = cyc - t0;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (lat < 0) begin
            bad++;
            $display("FAIL done_seen: no done within 4000 cycles on unit %0d", u);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   lat;
        int   t0;
        logic seen;
        logic dn;
        logic stray;

        // Latencies: 1+SETUP+80*DIV+sum(A)+DIV; ack after K cycles costs A=K+4-DIV
        // in ack states (2-flop sync plus one cycle in each ack state).
        vecs[0] = '{40'hFF7F5A41FF, 4'b0000, 1'b1, 1'b0, 8'h00, 16'hFFFF, 8,  141};
        vecs[1] = '{40'hFF7F5A41FF, 4'b1111, 1'b0, 1'b1, 8'h41, 16'hFF7F, 40, 349};
        vecs[2] = '{40'h34125A73FF, 4'b1111, 1'b0, 1'b1, 8'h73, 16'h3412, 40, 349};
        vecs[3] = '{40'h55AA0041FF, 4'b1111, 1'b0, 1'b0, 8'h41, 16'h3412, 40, 349};
        vecs[4] = '{40'hAA555A22FF, 4'b0011, 1'b1, 1'b0, 8'h41, 16'h3412, 24, 277};
        vecs[5] = '{40'hFF005A5AFF, 4'b1111, 1'b0, 1'b1, 8'h5A, 16'hFF00, 40, 349};

        ack_mask[0] = 4'b1111;
        ack_mask[1] = 4'b1111;
        for (int b = 0; b < 5; b++) begin
            reply_cfg[0][b] = 8'hFF;
            reply_cfg[1][b] = 8'hFF;
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_lines", {att_v[0], psx_clk_v[0], cmd_v[0]}, 3'b111);
        chk("reset_busy_done", {busy_v[0], done_v[0]}, 2'b00);
        chk("reset_to_valid", {to_v[0], valid_v[0]}, 2'b00);
        chk("reset_id", id_v[0], 8'h00);
        chk("reset_pad_data", pd_v[0], 16'hFFFF);

        for (int n = 0; n < 6; n++) begin
            for (int b = 0; b < 5; b++) reply_cfg[0][b] = vecs[n].rep[8*b +: 8];
            ack_mask[0] = vecs[n].mask;
            run_poll(0, lat);
            chk($sformatf("v%0d_latency", n), lat, vecs[n].exp_lat);
            chk($sformatf("v%0d_busy_at_done", n), busy_v[0], 1'b1);
            chk($sformatf("v%0d_timeout_err", n), to_v[0], vecs[n].exp_to);
            chk($sformatf("v%0d_valid", n), valid_v[0], vecs[n].exp_valid);
            chk($sformatf("v%0d_id", n), id_v[0], vecs[n].exp_id);
            chk($sformatf("v%0d_pad_data", n), pd_v[0], vecs[n].exp_pd);
            chk($sformatf("v%0d_falls", n), falls_of(0), vecs[n].exp_falls);
            if (!vecs[n].exp_to) begin
                for (int b = 0; b < 5; b++)
                    chk($sformatf("v%0d_cmd_byte%0d", n, b), cmd_of(0, b), cmd_exp[b]);
            end
            @(negedge clk);
            chk($sformatf("v%0d_idle_after", n), {busy_v[0], done_v[0], att_v[0]}, 3'b001);
        end

        // reset in the middle of byte 2
        for (int b = 0; b < 5; b++) reply_cfg[0][b] = vecs[1].rep[8*b +: 8];
        ack_mask[0] = 4'b1111;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (g_pad[0].bytn == 2 && g_pad[0].bitn == 3 && psx_clk_v[0] == 1'b0) seen = 1'b1;
        end
        chk("rst_reached_byte2", seen, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_lines", {att_v[0], psx_clk_v[0], cmd_v[0]}, 3'b111);
        chk("rst_async_busy", busy_v[0], 1'b0);
        chk("rst_async_pad_data", pd_v[0], 16'hFFFF);
        chk("rst_async_id", id_v[0], 8'h00);
        dn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            dn = dn | done_v[0];
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            dn = dn | done_v[0] | busy_v[0];
        end
        chk("rst_no_done", dn, 1'b0);
        run_poll(0, lat);
        chk("post_rst_latency", lat, 349);
        chk("post_rst_valid", {to_v[0], valid_v[0]}, 2'b01);
        chk("post_rst_id", id_v[0], 8'h41);
        chk("post_rst_pad_data", pd_v[0], 16'hFF7F);
        @(negedge clk);

        // start while busy and on the done cycle
        @(negedge clk);
        start_v[0] = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (50) @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = -1;
        for (int i = 0; i < 4000 && lat < 0; i++) begin
            @(negedge clk);
            if (done_v[0]) lat = cyc - t0;
        end
        chk("busy_start_latency", lat, 349);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        stray = 1'b0;
        repeat (40) begin
            if (!att_v[0] || busy_v[0]) stray = 1'b1;
            @(negedge clk);
        end
        chk("no_retrigger", stray, 1'b0);
        chk("busy_start_valid", valid_v[0], 1'b1);

        // CLK_DIV=3 unit, ack 20 cycles after each byte
        for (int b = 0; b < 5; b++) reply_cfg[1][b] = vecs[1].rep[8*b +: 8];
        ack_mask[1] = 4'b1111;
        run_poll(1, lat);
        chk("div3_latency", lat, 1 + SETUP + 80*DIV1 + 4*(20 + 4 - DIV1) + DIV1);
        chk("div3_status", {to_v[1], valid_v[1]}, 2'b01);
        chk("div3_id", id_v[1], 8'h41);
        chk("div3_pad_data", pd_v[1], 16'hFF7F);
        chk("div3_falls", falls_of(1), 40);
        for (int b = 0; b < 5; b++)
            chk($sformatf("div3_cmd_byte%0d", b), cmd_of(1, b), cmd_exp[b]);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/psx_poller.md
# psx_poller

Console-side initiator for the PSX digital-pad serial link. On a `start` pulse it asserts `att`, generates `psx_clk`, shifts out the standard poll command (0x01, 0x42, 0x00, 0x00, 0x00, LSB first), and samples the pad's 5-byte reply from `data`. It waits for the pad's `ack` pulse between bytes and reports the two button bytes, the pad ID, and status. This block is the host-side counterpart used to drive and test `fake_controller` and real pads from the FPGA fabric.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `psx_clk` half-period; must be ≥ 3.
- `SETUP_CYCLES`, 8: `clk` cycles from `att` falling to the first `psx_clk` fall.
- `ACK_TIMEOUT`, 64: maximum `clk` cycles to wait for a complete ack pulse after bytes 0–3.
- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin a poll; ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse at end of transaction (normal or aborted).
- `timeout_err` out 1: valid with `done`; held until the next accepted `start`.
- `valid` out 1: valid with `done`; 1 iff no timeout and reply byte2 == 0x5A. Held until next `start`.
- `id` out 8: reply byte1. Updated only on a successful `done`.
- `pad_data` out 16: {byte4, byte3}, active-low as on the wire. Updated only when `valid`.
- `psx_clk` out 1: serial clock, idles high.
- `cmd` out 1: command bit, idles high.
- `att` out 1: active-low select.
- `data` in 1: pad reply bit, asynchronous; 2-flop synchronized.
- `ack` in 1: active-low pad acknowledge, asynchronous; 2-flop synchronized.

## Operation
- States: IDLE, SETUP, BIT_LO, BIT_HI, ACK_LO, ACK_HI, RELEASE.
- IDLE: `start` → SETUP. `att` drops and `busy` rises on entry. Clear `timeout_err` and `valid`.
- SETUP: count `SETUP_CYCLES`, then → BIT_LO with bit 0 of byte 0.
- BIT_LO (`CLK_DIV` cycles): `psx_clk`=0, `cmd`=current command bit, driven on entry. On the last cycle, shift synchronized `data` into the byte shift register, LSB first (new bit enters at bit 7). Then → BIT_HI.
- BIT_HI (`CLK_DIV` cycles): `psx_clk`=1.
  - If bits remain in the byte → BIT_LO with the next bit.
  - After bit 7 of bytes 0–3 → ACK_LO.
  - After bit 7 of byte 4 → RELEASE.
- ACK_LO: wait for `ack_s`=0, then → ACK_HI.
- ACK_HI: wait for `ack_s`=1, then → BIT_LO with bit 0 of the next byte.
- The timeout counter starts on entry to ACK_LO and spans both ack states. If it reaches `ACK_TIMEOUT`: set `timeout_err`, → RELEASE immediately.
- RELEASE: drive `att`, `psx_clk`, `cmd` to 1. Hold for `CLK_DIV` cycles. Pulse `done`, drop `busy`, → IDLE.
- Reply bytes are captured into byte registers 0–4 as each completes.
- Counters: bit index 3 bits (wraps 7→0 with byte increment), byte index 3 bits (0–4), divider and timeout counters sized to their parameters.

## Timing
- Reset values:
  - `psx_clk`=1, `cmd`=1, `att`=1
  - `busy`=0, `done`=0
  - `timeout_err`=0, `valid`=0
  - `id`=8'h00, `pad_data`=16'hFFFF
  - state IDLE
- Reset mid-transaction returns every output to its reset value asynchronously. No `done` pulse is produced.
- Bit period: 2·`CLK_DIV` cycles.
- `data` is sampled 2 sync cycles late, on the final BIT_LO cycle. This is still before the `psx_clk` rising edge, which is why `CLK_DIV` ≥ 3.
- Nominal latency from `start`, with ack taking A_i cycles after byte i:
  - 1 + `SETUP_CYCLES` + 80·`CLK_DIV` + ΣA_i (i = 0–3) + `CLK_DIV` to `done`.
- Exactly 40 `psx_clk` falling edges per successful transaction.
- An ack arriving during BIT_LO/BIT_HI is ignored.
- A `start` coincident with `done` is ignored.

## Test plan
- Pad model replies FF 41 5A 7F FF with 1-cycle ack pulses after bytes 0–3:
  - Captured `cmd` bytes are 01 42 00 00 00.
  - `pad_data`=16'hFF7F, `id`=8'h41, `valid`=1, `timeout_err`=0.
  - 40 `psx_clk` falls.
- Ack never asserted after byte 0:
  - `done` fires `ACK_TIMEOUT`+`CLK_DIV` cycles after ACK_LO entry.
  - `timeout_err`=1, `valid`=0, `pad_data` stays 16'hFFFF.
  - 8 `psx_clk` falls total.
- Reply byte2 = 8'h00: `valid`=0, `pad_data` unchanged from its prior value, `id` updated.
- Assert `rst` during byte 2: `att`, `psx_clk`, `cmd` go to 1 in the same cycle, `busy`=0, no `done`. A following `start` completes normally.
- Pulse `start` while `busy` and on the `done` cycle: no second transaction, `att` stays high after RELEASE.
- `CLK_DIV`=3, ack delayed by 20 cycles after each byte: correct data captured, latency matches the Timing formula exactly.
